// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map (common with the execution block),
// the idle opcode driven between instructions, and the sequencer state enum.
package cpu_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned INSTR_W = 32;

  // ALU group occupies 6'b000xxx
  localparam logic [OP_W-1:0] OP_ADD = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b000001;
  localparam logic [OP_W-1:0] OP_AND = 6'b000010;
  localparam logic [OP_W-1:0] OP_OR  = 6'b000011;
  localparam logic [OP_W-1:0] OP_XOR = 6'b000100;
  localparam logic [OP_W-1:0] OP_NOT = 6'b000101;
  localparam logic [OP_W-1:0] OP_SHL = 6'b000110;
  localparam logic [OP_W-1:0] OP_SHR = 6'b000111;

  localparam logic [OP_W-1:0] OP_LD  = 6'b010000;
  localparam logic [OP_W-1:0] OP_ST  = 6'b010001;
  localparam logic [OP_W-1:0] OP_IN  = 6'b010010;
  localparam logic [OP_W-1:0] OP_OUT = 6'b010011;

  localparam logic [OP_W-1:0] OP_JV  = 6'b011100;
  localparam logic [OP_W-1:0] OP_JNV = 6'b011101;
  localparam logic [OP_W-1:0] OP_JZ  = 6'b011110;
  localparam logic [OP_W-1:0] OP_JNZ = 6'b011111;
  localparam logic [OP_W-1:0] OP_JMP = 6'b100000;
  localparam logic [OP_W-1:0] OP_RET = 6'b100001;
  localparam logic [OP_W-1:0] OP_HLT = 6'b111111;

  // JV leaves ans_ex and the flags untouched in the execution block
  localparam logic [OP_W-1:0] NOP_OP = OP_JV;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  function automatic logic is_alu(input logic [OP_W-1:0] op);
    return (op[5:3] == 3'b000);
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack. A push on a full stack overwrites the
// oldest entry; a pop on an empty stack is refused. Both set the sticky err.
// Ports: clk, reset (sync, active-low), push/pop strobes, push_data,
//        top_c (current top entry), empty_c, err (sticky, registered).
module ret_stack #(
  parameter int unsigned W       = 10,
  parameter int unsigned STACK_D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_c,
  output logic         empty_c,
  output logic         err
);

  localparam int unsigned PTR_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam int unsigned CNT_W = $clog2(STACK_D + 1);

  logic [W-1:0]     mem [STACK_D];
  logic [PTR_W-1:0] ptr;   // next free slot; wraps naturally (power-of-two depth)
  logic [CNT_W-1:0] cnt;
  logic             full_c;

  assign full_c  = (cnt == CNT_W'(STACK_D));
  assign empty_c = (cnt == '0);
  assign top_c   = mem[ptr - PTR_W'(1)];

  // Pointer, occupancy and sticky error
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (full_c) err <= 1'b1;
      else        cnt <= cnt + CNT_W'(1);
    end else if (pop) begin
      if (empty_c) begin
        err <= 1'b1;
      end else begin
        ptr <= ptr - PTR_W'(1);
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Storage, no reset needed: occupancy gates all reads
  always_ff @(posedge clk) begin
    if (reset && push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, one-cycle execute,
// data-memory handshake, register write-back, jumps and a return stack.
// Ports: clk, reset (sync, active-low); imem_addr/req/ack/rdata fetch port;
//        instr (latched word); op_dec to execution block; flag_ex from it;
//        dm_req/dm_we/dm_ack data-memory handshake; rf_we/rf_wsel write-back;
//        pc; halted/resume; stack_err (sticky). All outputs are registered.
module exec_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned STACK_D = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op_dec,
  input  logic [1:0]         flag_ex,
  output logic               dm_req,
  output logic               dm_we,
  input  logic               dm_ack,
  output logic               rf_we,
  output logic               rf_wsel,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  input  logic               resume,
  output logic               stack_err
);

  state_t               state, state_n;
  logic [PC_W-1:0]      pc_n, pc_inc, target, stack_top;
  logic [INSTR_W-1:0]   instr_n;
  logic [OP_W-1:0]      op;
  logic                 push, pop, stack_empty;

  assign op        = instr[31:26];
  assign target    = instr[PC_W-1:0];
  assign pc_inc    = pc + PC_W'(1);
  assign imem_addr = pc;

  ret_stack #(.W(PC_W), .STACK_D(STACK_D)) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_c     (stack_top),
    .empty_c   (stack_empty),
    .err       (stack_err)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_BOOT;
    else        state <= state_n;
  end

  // Next state, next pc/instr and stack strobes
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr;
    push    = 1'b0;
    pop     = 1'b0;
    case (state)
      S_BOOT:  state_n = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_n = imem_rdata;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        state_n = S_FETCH;
        pc_n    = pc_inc;
        if (is_alu(op) || op == OP_IN || op == OP_LD || op == OP_ST || op == OP_OUT) begin
          state_n = S_EXEC;
          pc_n    = pc;
        end else begin
          case (op)
            OP_JMP: begin
              push = 1'b1;
              pc_n = target;
            end
            OP_JV:  if (flag_ex[0])  pc_n = target;
            OP_JNV: if (!flag_ex[0]) pc_n = target;
            OP_JZ:  if (flag_ex[1])  pc_n = target;
            OP_JNZ: if (!flag_ex[1]) pc_n = target;
            OP_RET: begin
              pop = 1'b1;
              if (!stack_empty) pc_n = stack_top;
            end
            OP_HLT: begin
              state_n = S_HALT;
              pc_n    = pc;
            end
            default: ;
          endcase
        end
      end
      S_EXEC: begin
        if (op == OP_LD || op == OP_ST) begin
          state_n = S_MEM;
        end else if (op == OP_OUT) begin
          state_n = S_FETCH;
          pc_n    = pc_inc;
        end else begin
          state_n = S_WB;
        end
      end
      S_MEM: begin
        if (dm_ack) begin
          if (op == OP_LD) begin
            state_n = S_WB;
          end else begin
            state_n = S_FETCH;
            pc_n    = pc_inc;
          end
        end
      end
      S_WB: begin
        state_n = S_FETCH;
        pc_n    = pc_inc;
      end
      S_HALT: begin
        if (resume) begin
          state_n = S_FETCH;
          pc_n    = pc_inc;
        end
      end
      default: state_n = S_BOOT;
    endcase
  end

  // Moore outputs registered from the upcoming state
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= '0;
      instr    <= '0;
      op_dec   <= NOP_OP;
      imem_req <= 1'b0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      rf_we    <= 1'b0;
      rf_wsel  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      pc       <= pc_n;
      instr    <= instr_n;
      op_dec   <= (state_n == S_EXEC) ? instr_n[31:26] : NOP_OP;
      imem_req <= (state_n == S_FETCH);
      dm_req   <= (state_n == S_MEM);
      dm_we    <= (state_n == S_MEM) && (instr_n[31:26] == OP_ST);
      rf_we    <= (state_n == S_WB);
      rf_wsel  <= (state_n == S_WB) && (instr_n[31:26] == OP_LD);
      halted   <= (state_n == S_HALT);
    end
  end

endmodule
